// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small first-in first-out buffer.
// Frames are start bit, LSB-first data, optional parity, then one or two stop bits.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 2604,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 sci_tx,
  output logic                 tx_busy,
  output logic                 tx_d_end,
  output logic                 frame_done,
  output logic [2:0]           dbg_state
);

  localparam int             PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [15:0]    DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic           ODD       = (PARITY == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t state_q, state_d;

  // Handshake: a word is written on any rising edge where tx_valid and tx_ready
  // are both high; tx_ready depends only on the registered fill level.
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       count;
  logic                 push, pop, fifo_empty;
  logic [DATA_BITS-1:0] head;

  assign fifo_empty = (count == '0);
  assign tx_ready   = (count != FULL_CNT);
  assign push       = tx_valid && tx_ready;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  logic [15:0]          div_q, div_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 sci_q, sci_d;
  logic                 done_q, done_d;
  logic                 bit_end, load;

  assign bit_end = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    sci_d   = sci_q;
    done_d  = 1'b0;
    load    = 1'b0;
    pop     = 1'b0;
    if (state_q != IDLE && !bit_end) div_d = div_q + 16'd1;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          sci_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = PAR;
              sci_d   = par_q;
            end else begin
              state_d = STOP;
              sci_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q >> 1;
            sci_d   = shift_q[1];
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
          sci_d   = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            done_d = 1'b1;
            // Chain straight into the next start bit when more words wait.
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              sci_d   = 1'b1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      pop     = 1'b1;
      shift_d = head;
      par_d   = (^head) ^ ODD;
      state_d = START;
      bit_d   = '0;
      sci_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      sci_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      sci_q   <= sci_d;
      done_q  <= done_d;
    end
  end

  assign sci_tx     = sci_q;
  assign frame_done = done_q;
  assign tx_busy    = (state_q != IDLE);
  assign tx_d_end   = !tx_busy && fifo_empty;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances (8N1, 7E2, 7O2 at 4 clocks/bit, 8N1 at 2604)
// compared every cycle against a frame-level model, plus literal waveform checks.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cdiv_of(int i);  return (i == 3) ? 2604 : 4;              endfunction
  function automatic int dbits_of(int i); return (i == 1 || i == 2) ? 7 : 8;       endfunction
  function automatic int par_of(int i);   return (i == 1) ? 2 : ((i == 2) ? 1 : 0); endfunction
  function automatic int stop_of(int i);  return (i == 1 || i == 2) ? 2 : 1;       endfunction

  logic       rst   [4];
  logic       valid [4];
  logic [8:0] data  [4];
  logic       ready [4];
  logic       sci   [4];
  logic       busy  [4];
  logic       dend  [4];
  logic       done  [4];
  logic [2:0] st    [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int DB = dbits_of(g);
    uart_tx_fifo #(
      .CLK_DIV(cdiv_of(g)), .DATA_BITS(DB), .PARITY(par_of(g)),
      .STOP_BITS(stop_of(g)), .FIFO_DEPTH(4)
    ) u_dut (
      .clk(clk), .rst_n(rst[g]), .tx_data(data[g][DB-1:0]), .tx_valid(valid[g]),
      .tx_ready(ready[g]), .sci_tx(sci[g]), .tx_busy(busy[g]), .tx_d_end(dend[g]),
      .frame_done(done[g]), .dbg_state(st[g])
    );
  end

  function automatic void check(string name, int i, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", name, i, cyc, act, exp);
    end
  endfunction

  // Model: a queue of buffered words and the level list of the frame on the line.
  logic [8:0]  mq   [4][$];
  logic [15:0] fv   [4];
  int          fn   [4];
  int          pos  [4];
  logic        infr [4];
  logic        edone[4];

  initial begin
    for (int i = 0; i < 4; i++) begin
      fv[i] = '1; fn[i] = 1; pos[i] = 0; infr[i] = 1'b0; edone[i] = 1'b0;
    end
  end

  function automatic logic [15:0] build_frame(int i, logic [8:0] w);
    logic [15:0] v;
    logic        p;
    int          k;
    v = '0;
    p = 1'b0;
    k = 1;
    for (int b = 0; b < dbits_of(i); b++) begin
      v[k] = w[b];
      p    = p ^ w[b];
      k++;
    end
    if (par_of(i) != 0) begin
      v[k] = (par_of(i) == 1) ? ~p : p;
      k++;
    end
    for (int s = 0; s < stop_of(i); s++) begin
      v[k] = 1'b1;
      k++;
    end
    return v;
  endfunction

  function automatic void model_step();
    for (int i = 0; i < 4; i++) begin
      int         cd;
      logic       rp;
      logic       fin;
      logic [8:0] w;
      cd = cdiv_of(i);
      rp = (mq[i].size() < 4);
      edone[i] = 1'b0;
      if (rst[i] === 1'b1) begin
        mq[i].delete();
        infr[i] = 1'b0;
        pos[i]  = 0;
      end else begin
        fin = infr[i] && (pos[i] == fn[i] * cd - 1);
        if (infr[i] && !fin) begin
          pos[i]++;
        end else begin
          edone[i] = fin;
          if (mq[i].size() != 0) begin
            w       = mq[i].pop_front();
            fv[i]   = build_frame(i, w);
            fn[i]   = 1 + dbits_of(i) + ((par_of(i) != 0) ? 1 : 0) + stop_of(i);
            pos[i]  = 0;
            infr[i] = 1'b1;
          end else begin
            infr[i] = 1'b0;
          end
        end
        if (valid[i] === 1'b1 && rp) mq[i].push_back(data[i]);
      end
    end
  endfunction

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        check("sci_tx", i, sci[i], infr[i] ? fv[i][pos[i] / cdiv_of(i)] : 1'b1);
        check("tx_busy", i, busy[i], infr[i]);
        check("tx_d_end", i, dend[i], !infr[i] && mq[i].size() == 0);
        check("tx_ready", i, ready[i], mq[i].size() < 4);
        check("frame_done", i, done[i], edone[i]);
      end
    end
  end

  task automatic push(input int i, input logic [8:0] w);
    @(negedge clk);
    valid[i] = 1'b1;
    data[i]  = w;
    @(negedge clk);
    valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int t;
    t = 0;
    while (dend[i] !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait", i, t < 2000, 1'b1);
  endtask

  // Locates the start bit, samples every bit mid-way against a literal frame,
  // checks transitions sit on bit boundaries and times the frame_done pulse.
  task automatic capture(input int i, input logic [15:0] exp_bits, input int nb);
    int   cd;
    int   t;
    int   pulses;
    logic prev;
    cd = cdiv_of(i);
    t = 0;
    pulses = 0;
    while (sci[i] !== 1'b0 && t < 64) begin
      @(negedge clk);
      t++;
    end
    check("start_seen", i, t < 64, 1'b1);
    if (t < 64) begin
      prev = 1'b0;
      for (int n = 0; n <= nb * cd + 4; n++) begin
        if (n % cd == cd / 2 && n / cd < nb) check("frame_bit", i, sci[i], exp_bits[n / cd]);
        if (n > 0 && sci[i] !== prev) check("bit_edge", i, n % cd, 0);
        prev = sci[i];
        if (done[i] === 1'b1) begin
          pulses++;
          check("done_at", i, n, nb * cd);
        end
        @(negedge clk);
      end
      check("done_pulses", i, pulses, 1);
    end
  endtask

  initial begin
    int acc, last_rdy, busy_cnt, first, end_n, start, busy_after;
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; valid[i] = 1'b0; data[i] = '0;
    end
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("rst_sci", i, sci[i], 1'b1);
      check("rst_busy", i, busy[i], 1'b0);
      check("rst_d_end", i, dend[i], 1'b1);
      check("rst_ready", i, ready[i], 1'b1);
      check("rst_done", i, done[i], 1'b0);
      check("rst_state", i, st[i], 3'd0);
    end
    valid[0] = 1'b1;
    data[0]  = 9'h0AA;
    @(negedge clk);
    check("rst_priority", 0, dend[0], 1'b1);
    valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;

    // 0x55 at 2604 clocks/bit: start 0, 1,0,1,0,1,0,1,0, stop 1.
    push(3, 9'h055);
    fork
      capture(3, 16'h02AA, 10);
    join_none

    // 0xA5 8N1: 0,1,0,1,0,0,1,0,1,1.
    push(0, 9'h0A5);
    capture(0, 16'h034A, 10);

    // 0x03 7-bit, two stops: even parity bit 0, odd parity bit 1.
    @(negedge clk);
    valid[1] = 1'b1; data[1] = 9'h003;
    valid[2] = 1'b1; data[2] = 9'h003;
    @(negedge clk);
    valid[1] = 1'b0;
    valid[2] = 1'b0;
    fork
      capture(1, 16'h0606, 11);
      capture(2, 16'h0706, 11);
    join

    // Six back-to-back writes from idle: five accepted, five contiguous frames.
    wait_idle(0);
    acc = 0; last_rdy = 1; busy_cnt = 0; first = -1; end_n = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (n < 6) begin
        valid[0] = 1'b1;
        data[0]  = 9'($urandom_range(0, 255));
        if (ready[0] === 1'b1) acc++;
        last_rdy = (ready[0] === 1'b1) ? 1 : 0;
      end else begin
        valid[0] = 1'b0;
      end
      if (busy[0] === 1'b1) busy_cnt++;
      if (busy[0] === 1'b1 && first < 0) first = n;
      if (n > 6 && dend[0] === 1'b1) begin
        end_n = n;
        break;
      end
    end
    valid[0] = 1'b0;
    check("accepted", 0, acc, 5);
    check("sixth_ready", 0, last_rdy, 0);
    check("busy_cycles", 0, busy_cnt, 200);
    check("busy_span", 0, end_n - first, 200);

    // Reset during data bit 3 of 0xFF with two words queued.
    wait_idle(0);
    start = -1;
    for (int m = 0; m < 60; m++) begin
      @(negedge clk);
      if (m < 3) begin
        valid[0] = 1'b1;
        data[0]  = (m == 0) ? 9'h0FF : ((m == 1) ? 9'h011 : 9'h022);
      end else begin
        valid[0] = 1'b0;
      end
      if (start < 0 && sci[0] === 1'b0) start = m;
      if (start >= 0 && m == start + 17) begin
        rst[0] = 1'b1;
        break;
      end
    end
    valid[0] = 1'b0;
    check("mid_rst_reached", 0, rst[0], 1'b1);
    @(negedge clk);
    check("mid_rst_sci", 0, sci[0], 1'b1);
    check("mid_rst_d_end", 0, dend[0], 1'b1);
    check("mid_rst_ready", 0, ready[0], 1'b1);
    check("mid_rst_busy", 0, busy[0], 1'b0);
    rst[0] = 1'b0;
    busy_after = 0;
    for (int m = 0; m < 100; m++) begin
      @(negedge clk);
      if (busy[0] === 1'b1) busy_after++;
    end
    check("no_frames_after_rst", 0, busy_after, 0);

    // Random traffic with occasional resets on the parity instances.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        valid[i] = ($urandom_range(0, 3) == 0);
        data[i]  = 9'($urandom_range(0, 511));
        rst[i]   = (i != 0) && ($urandom_range(0, 299) == 0);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0;
      rst[i]   = 1'b0;
    end
    for (int i = 0; i < 3; i++) wait_idle(i);

    wait fork;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
